ksa_iter_ctrl: RTL and testbench
================================

Name: ksa_iter_ctrl

Overview:
Iterative sequencer for a masked Kogge-Stone prefix network in the B2A path. It time-shares one masked generate/propagate stage, whose shift is selected at runtime, across all N_ROUNDS prefix rounds. For each round it holds the share-wise p/g state, fetches fresh randomness, issues the stage, waits for the stage's valid and feeds the result back. It returns the final masked carry vector g to the B2A top through a valid/ready handshake.

Parameters:
K_WIDTH, 32, bit width of each share
N_SHARES, 3, number of Boolean shares
MASKWIDTH, K_WIDTH*N_SHARES, width of a packed share vector
RANDNUM, 2*N_SHARES*(N_SHARES-1), number of K_WIDTH random words consumed per round
N_ROUNDS, $clog2(K_WIDTH), number of prefix rounds
TIMEOUT, 15, maximum cycles to wait for st_ovld before aborting

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_vld  in  1  input p/g shares valid
i_rdy  out  1  controller can accept new operands
i_p  in  MASKWIDTH  initial masked propagate (a^b per share)
i_g  in  MASKWIDTH  initial masked generate (a&b, already share-wise masked)
rnd_req  out  1  request one round of randomness
rnd_vld  in  1  randomness word valid
rnd  in  K_WIDTH*RANDNUM  randomness for one round
st_dvld  out  1  stage data-valid strobe
st_ena  out  1  stage enable
st_round  out  $clog2(N_ROUNDS)  round index r; stage shift is 2^r
st_p  out  MASKWIDTH  p shares to stage
st_g  out  MASKWIDTH  g shares to stage
st_rnd  out  K_WIDTH*RANDNUM  randomness to stage
st_ovld  in  1  stage result valid
st_p_res  in  MASKWIDTH  stage p result
st_g_res  in  MASKWIDTH  stage g result
o_vld  out  1  final carry shares valid
o_rdy  in  1  downstream accepts
o_g  out  MASKWIDTH  final masked carry vector
o_err  out  1  one-cycle pulse on stage timeout

Behaviour:
Interface: one clock, clk. Reset rst_n is asynchronous and active-low.

Reset:
- FSM goes to IDLE.
- Round counter, timeout counter, p_reg, g_reg and rnd_reg clear to 0.
- All outputs are 0, except i_rdy=1 in IDLE.

FSM states: IDLE, RND, ISSUE, WAIT, DONE.
- IDLE
  - i_rdy=1.
  - On i_vld: latch i_p/i_g into p_reg/g_reg, set round=0, go to RND.
- RND
  - rnd_req=1.
  - On rnd_vld: latch rnd into rnd_reg, go to ISSUE.
  - Randomness is never reused across rounds.
- ISSUE (exactly one cycle)
  - st_dvld=1, st_ena=1.
  - st_p=p_reg, st_g=g_reg, st_rnd=rnd_reg, st_round=round.
  - Go to WAIT; clear timeout counter.
- WAIT
  - st_ena=1, st_dvld=0. st_p/st_g/st_rnd/st_round stay stable.
  - On st_ovld:
    - p_reg<=st_p_res, g_reg<=st_g_res, rnd_reg<=0.
    - If round==N_ROUNDS-1: go to DONE.
    - Otherwise: round<=round+1, go to RND.
  - If timeout counter reaches TIMEOUT without st_ovld:
    - o_err pulses for 1 cycle.
    - p_reg, g_reg and rnd_reg clear; go to IDLE.
- DONE
  - o_vld=1, o_g=g_reg, held stable until o_rdy.
  - On o_rdy: clear p_reg/g_reg, go to IDLE.
  - i_rdy=0 in DONE, so a new operand cannot be accepted in the same cycle as the handshake; earliest next accept is the following cycle.

Latency and data-path rules:
- Latency per round = 1 (RND, if rnd_vld is already high) + 1 (ISSUE) + stage latency.
- Total latency = N_ROUNDS × that figure + 1 (DONE).
- No arithmetic on share data inside the controller; shares only move register to register, and shares are never XOR-combined.
- st_ovld outside WAIT is ignored.
- rnd_vld outside RND is ignored.
- Reset asserted mid-operation aborts immediately, with no output pulse.

Decomposition:
- Package ksa_pkg holds:
  - state enum (IDLE, RND, ISSUE, WAIT, DONE);
  - functions for MASKWIDTH, RANDNUM and N_ROUNDS;
  - ROUND_W = $clog2(N_ROUNDS).
- One natural sub-module, ksa_share_regfile: the p/g/rnd holding registers with load/clear controls, built on the team's existing enabled register primitive.

Test Plan:
Bench uses K_WIDTH=8, N_SHARES=2, and a behavioural stage model: 2-cycle latency, g'=g^(p&(g<<2^r)), p'=p&(p<<2^r), random remasking.
1. Carry chain: a=0x0F, b=0x01, shares masked with 0xA5 -> 3 rounds, st_round=0,1,2, 3 rnd_req handshakes; XOR of o_g shares=0x0F.
2. Full carry: a=0xFF, b=0x01 -> o_g recombines to 0xFF; o_vld held 5 cycles with o_rdy=0, o_g unchanged; on o_rdy, i_rdy=1 the next cycle.
3. Randomness stall: rnd_vld delayed 4 cycles in round 1 -> rnd_req held, st_dvld stays 0, result unchanged (0x0F for case 1).
4. Timeout: stage model never asserts st_ovld in round 2 -> o_err pulses once at WAIT cycle 15; FSM returns to IDLE; p_reg/g_reg read 0.
5. Reset mid-WAIT: rst_n low during round 1 -> all outputs 0 asynchronously, i_rdy=1 after release; a new op a=0x03, b=0x01 gives o_g=0x03.
6. Ignored inputs: spurious st_ovld in IDLE and rnd_vld in WAIT -> no state change, no register update.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared state encoding and sizing helpers for the iterative masked
// Kogge-Stone prefix controller.
package ksa_pkg;

  typedef enum logic [2:0] {IDLE, RND, ISSUE, WAIT, DONE} state_e;

  function automatic int f_maskwidth(input int k_width, input int n_shares);
    return k_width * n_shares;
  endfunction

  function automatic int f_randnum(input int n_shares);
    return 2 * n_shares * (n_shares - 1);
  endfunction

  function automatic int f_rounds(input int k_width);
    return $clog2(k_width);
  endfunction

  // Round index needs at least one bit even for a single-round network.
  function automatic int f_round_w(input int n_rounds);
    return (n_rounds > 1) ? $clog2(n_rounds) : 1;
  endfunction

  localparam int ROUND_W = f_round_w(f_rounds(32));

endpackage

// File: rtl/ksa_share_regfile.sv
// Holding registers for the share-wise p/g state and the current round's
// randomness; data only moves register to register, never combined.
module ksa_share_regfile #(
  parameter int MASKWIDTH = 96,
  parameter int RNDWIDTH  = 384
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_in,
  input  logic                 ld_res,
  input  logic                 clr_pg,
  input  logic                 ld_rnd,
  input  logic                 clr_rnd,
  input  logic [MASKWIDTH-1:0] in_p,
  input  logic [MASKWIDTH-1:0] in_g,
  input  logic [MASKWIDTH-1:0] res_p,
  input  logic [MASKWIDTH-1:0] res_g,
  input  logic [RNDWIDTH-1:0]  in_rnd,
  output logic [MASKWIDTH-1:0] p_q,
  output logic [MASKWIDTH-1:0] g_q,
  output logic [RNDWIDTH-1:0]  rnd_q
);

  logic                 pg_en, rnd_en;
  logic [MASKWIDTH-1:0] p_d, g_d;
  logic [RNDWIDTH-1:0]  rnd_d;

  // Clear wins over load so an abort can never leave stale shares behind.
  always_comb begin
    pg_en  = clr_pg | ld_in | ld_res;
    rnd_en = clr_rnd | ld_rnd;
    p_d    = res_p;
    g_d    = res_g;
    rnd_d  = in_rnd;
    if (clr_pg) begin
      p_d = '0;
      g_d = '0;
    end else if (ld_in) begin
      p_d = in_p;
      g_d = in_g;
    end
    if (clr_rnd) begin
      rnd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      g_q   <= '0;
      rnd_q <= '0;
    end else begin
      if (pg_en) begin
        p_q <= p_d;
        g_q <= g_d;
      end
      if (rnd_en) begin
        rnd_q <= rnd_d;
      end
    end
  end

endmodule

// File: rtl/ksa_iter_ctrl.sv
// Sequencer that time-shares one masked prefix stage across all Kogge-Stone
// rounds, fetching fresh randomness per round and returning the carry shares.
module ksa_iter_ctrl
  import ksa_pkg::*;
#(
  parameter int K_WIDTH    = 32,
  parameter int N_SHARES   = 3,
  parameter int MASKWIDTH  = f_maskwidth(K_WIDTH, N_SHARES),
  parameter int RANDNUM    = f_randnum(N_SHARES),
  parameter int N_ROUNDS   = f_rounds(K_WIDTH),
  parameter int TIMEOUT    = 15,
  parameter int ST_ROUND_W = f_round_w(N_ROUNDS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_vld,
  output logic                         i_rdy,
  input  logic [MASKWIDTH-1:0]         i_p,
  input  logic [MASKWIDTH-1:0]         i_g,
  output logic                         rnd_req,
  input  logic                         rnd_vld,
  input  logic [K_WIDTH*RANDNUM-1:0]   rnd,
  output logic                         st_dvld,
  output logic                         st_ena,
  output logic [ST_ROUND_W-1:0]        st_round,
  output logic [MASKWIDTH-1:0]         st_p,
  output logic [MASKWIDTH-1:0]         st_g,
  output logic [K_WIDTH*RANDNUM-1:0]   st_rnd,
  input  logic                         st_ovld,
  input  logic [MASKWIDTH-1:0]         st_p_res,
  input  logic [MASKWIDTH-1:0]         st_g_res,
  output logic                         o_vld,
  input  logic                         o_rdy,
  output logic [MASKWIDTH-1:0]         o_g,
  output logic                         o_err
);

  localparam int RNDW  = K_WIDTH * RANDNUM;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ST_ROUND_W-1:0] LAST_ROUND = ST_ROUND_W'(N_ROUNDS - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST   = TMO_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [ST_ROUND_W-1:0] round_q, round_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  i_rdy_q, i_rdy_d, rnd_req_q, rnd_req_d;
  logic                  st_dvld_q, st_dvld_d, st_ena_q, st_ena_d;
  logic                  o_vld_q, o_vld_d, o_err_q, o_err_d;
  logic                  ld_in, ld_res, clr_pg, ld_rnd, clr_rnd;
  logic [MASKWIDTH-1:0]  p_q, g_q;
  logic [RNDW-1:0]       rnd_q;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    tmo_d   = tmo_q;
    o_err_d = 1'b0;
    ld_in   = 1'b0;
    ld_res  = 1'b0;
    clr_pg  = 1'b0;
    ld_rnd  = 1'b0;
    clr_rnd = 1'b0;
    unique case (state_q)
      IDLE: if (i_vld) begin
        ld_in   = 1'b1;
        round_d = '0;
        state_d = RND;
      end
      RND: if (rnd_vld) begin
        ld_rnd  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving in the last permitted cycle still counts.
        if (st_ovld) begin
          ld_res  = 1'b1;
          clr_rnd = 1'b1;
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 1'b1;
            state_d = RND;
          end
        end else if (tmo_q == TMO_LAST) begin
          o_err_d = 1'b1;
          clr_pg  = 1'b1;
          clr_rnd = 1'b1;
          round_d = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: if (o_rdy) begin
        clr_pg  = 1'b1;
        round_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    i_rdy_d   = (state_d == IDLE);
    rnd_req_d = (state_d == RND);
    st_dvld_d = (state_d == ISSUE);
    st_ena_d  = (state_d == ISSUE) || (state_d == WAIT);
    o_vld_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      round_q   <= '0;
      tmo_q     <= '0;
      i_rdy_q   <= 1'b1;
      rnd_req_q <= 1'b0;
      st_dvld_q <= 1'b0;
      st_ena_q  <= 1'b0;
      o_vld_q   <= 1'b0;
      o_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      tmo_q     <= tmo_d;
      i_rdy_q   <= i_rdy_d;
      rnd_req_q <= rnd_req_d;
      st_dvld_q <= st_dvld_d;
      st_ena_q  <= st_ena_d;
      o_vld_q   <= o_vld_d;
      o_err_q   <= o_err_d;
    end
  end

  ksa_share_regfile #(
    .MASKWIDTH (MASKWIDTH),
    .RNDWIDTH  (RNDW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_in   (ld_in),
    .ld_res  (ld_res),
    .clr_pg  (clr_pg),
    .ld_rnd  (ld_rnd),
    .clr_rnd (clr_rnd),
    .in_p    (i_p),
    .in_g    (i_g),
    .res_p   (st_p_res),
    .res_g   (st_g_res),
    .in_rnd  (rnd),
    .p_q     (p_q),
    .g_q     (g_q),
    .rnd_q   (rnd_q)
  );

  assign i_rdy    = i_rdy_q;
  assign rnd_req  = rnd_req_q;
  assign st_dvld  = st_dvld_q;
  assign st_ena   = st_ena_q;
  assign st_round = round_q;
  assign st_p     = p_q;
  assign st_g     = g_q;
  assign st_rnd   = rnd_q;
  assign o_vld    = o_vld_q;
  assign o_g      = g_q;
  assign o_err    = o_err_q;

endmodule

// File: tb/tb_ksa_iter_ctrl.sv
// Scoreboard bench for ksa_iter_ctrl with a behavioural masked prefix stage.
module tb_ksa_iter_ctrl;

  localparam int KW  = 8;
  localparam int MW  = 16;
  localparam int RW  = 32;
  localparam int SRW = 2;

  typedef struct packed {
    logic       is_err;
    logic [7:0] g;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_vld = 1'b0;
  logic          i_rdy;
  logic [MW-1:0] i_p = '0, i_g = '0;
  logic          rnd_req;
  logic          rnd_vld = 1'b0;
  logic [RW-1:0] rnd = '0;
  logic          st_dvld, st_ena;
  logic [SRW-1:0] st_round;
  logic [MW-1:0] st_p, st_g;
  logic [RW-1:0] st_rnd;
  logic          st_ovld = 1'b0;
  logic [MW-1:0] st_p_res = '0, st_g_res = '0;
  logic          o_vld;
  logic          o_rdy = 1'b1;
  logic [MW-1:0] o_g;
  logic          o_err;

  int   checks = 0, failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   rnd_hs = 0, issues = 0, drop_cyc = 0;
  logic [RW-1:0] last_rnd = '0;
  int   drop_round = -1;
  bit   stall_r1 = 1'b0;
  int   spur_ovld_cnt = 0, spur_rnd_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ksa_iter_ctrl #(.K_WIDTH(KW), .N_SHARES(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy), .i_p(i_p), .i_g(i_g),
    .rnd_req(rnd_req), .rnd_vld(rnd_vld), .rnd(rnd), .st_dvld(st_dvld), .st_ena(st_ena),
    .st_round(st_round), .st_p(st_p), .st_g(st_g), .st_rnd(st_rnd), .st_ovld(st_ovld),
    .st_p_res(st_p_res), .st_g_res(st_g_res), .o_vld(o_vld), .o_rdy(o_rdy), .o_g(o_g),
    .o_err(o_err)
  );

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] comb2(input logic [MW-1:0] v);
    return v[7:0] ^ v[15:8];
  endfunction

  function automatic logic [MW-1:0] split(input logic [7:0] v, input logic [7:0] m);
    return {m, v ^ m};
  endfunction

  // Carry out of bit i is whether the low i+1 bits of a and b overflow.
  function automatic logic [7:0] ref_carries(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    int lim, s;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      lim = 1 << (i + 1);
      s = (int'(a) % lim) + (int'(b) % lim);
      c[i] = (s >= lim);
    end
    return c;
  endfunction

  // Behavioural stage: 2-cycle latency, recombine, prefix step, remask.
  initial begin : stage_model
    logic [MW-1:0] cp, cg;
    logic [RW-1:0] cr;
    logic [SRW-1:0] round_exp, cround;
    logic [7:0] pv, gv, pn, gn;
    int sh, spur_done;
    round_exp = '0;
    spur_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        round_exp = '0;
        continue;
      end
      if (i_rdy) round_exp = '0;
      if (spur_ovld_cnt != spur_done) begin
        spur_done++;
        st_p_res = MW'($urandom);
        st_g_res = MW'($urandom);
        st_ovld = 1'b1;
        @(negedge clk);
        st_ovld = 1'b0;
        continue;
      end
      if (st_dvld) begin
        check("st_round", st_round == round_exp, 64'(st_round), 64'(round_exp));
        check("st_rnd_fresh", st_rnd == last_rnd, 64'(st_rnd), 64'(last_rnd));
        issues++;
        cp = st_p; cg = st_g; cr = st_rnd; cround = st_round;
        round_exp++;
        if (drop_round == int'(cround)) begin
          drop_cyc = cyc;
          continue;
        end
        @(negedge clk);
        if (rst_n)
          check("st_hold1", st_ena && !st_dvld && st_p == cp && st_g == cg && st_rnd == cr,
                {st_ena, st_dvld, st_rnd}, {1'b1, 1'b0, cr});
        @(negedge clk);
        if (!rst_n) continue;
        check("st_hold2", st_ena && !st_dvld && st_p == cp && st_g == cg && st_rnd == cr,
              {st_ena, st_dvld, st_rnd}, {1'b1, 1'b0, cr});
        sh = 1 << int'(cround);
        pv = comb2(cp);
        gv = comb2(cg);
        gn = gv ^ (pv & (gv << sh));
        pn = pv & (pv << sh);
        st_p_res = split(pn, 8'($urandom));
        st_g_res = split(gn, 8'($urandom));
        st_ovld = 1'b1;
        @(negedge clk);
        st_ovld = 1'b0;
      end
    end
  end

  // Randomness source: random 0-2 cycle latency, forced 4-cycle stall in round 1.
  initial begin : rnd_drv
    int spur_done, d;
    spur_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (rnd_req) begin
        if (stall_r1 && st_round == 2'd1) begin
          for (int k = 0; k < 4; k++) begin
            check("rnd_stall", rnd_req && !st_dvld, {rnd_req, st_dvld}, 2'b10);
            @(negedge clk);
          end
        end else begin
          d = $urandom_range(0, 2);
          repeat (d) @(negedge clk);
        end
        rnd = $urandom;
        last_rnd = rnd;
        rnd_vld = 1'b1;
        rnd_hs++;
        @(negedge clk);
        rnd_vld = 1'b0;
      end else if (spur_rnd_cnt != spur_done && st_ena && !st_dvld) begin
        spur_done++;
        rnd = $urandom;
        rnd_vld = 1'b1;
        @(negedge clk);
        rnd_vld = 1'b0;
      end
    end
  end

  initial begin : monitor
    bit vprev, eprev;
    exp_t e;
    vprev = 1'b0;
    eprev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_vld && !vprev) begin
        if (exp_q.size() == 0) check("unexpected_o_vld", 1'b0, 64'(comb2(o_g)), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("o_g", !e.is_err && comb2(o_g) == e.g, {e.is_err, comb2(o_g)}, {1'b0, e.g});
        end
      end
      if (o_err) begin
        if (eprev) check("o_err_single", 1'b0, 64'd1, 64'd0);
        else if (exp_q.size() == 0) check("unexpected_o_err", 1'b0, 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("o_err_expected", e.is_err == 1'b1, 64'(e.is_err), 64'd1);
          check("o_err_cycle", cyc - drop_cyc == 16, 64'(cyc - drop_cyc), 64'd16);
        end
      end
      vprev = o_vld;
      eprev = o_err;
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] mp,
                        input logic [7:0] mg, input bit exp_err);
    exp_t e;
    int n;
    n = 0;
    while (!i_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("i_rdy_wait", i_rdy, 64'(i_rdy), 64'd1);
    i_p = split(a ^ b, mp);
    i_g = split(a & b, mg);
    i_vld = 1'b1;
    e.is_err = exp_err;
    e.g = exp_err ? 8'h00 : ref_carries(a, b);
    exp_q.push_back(e);
    @(negedge clk);
    i_vld = 1'b0;
    i_p = MW'($urandom);
    i_g = MW'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    int h0, i0, n;
    bit found;
    logic [MW-1:0] gsnap;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rnd_req, st_dvld, st_ena, o_vld, o_err, st_round} == '0 && st_p == '0 &&
          st_g == '0 && st_rnd == '0 && o_g == '0 && i_rdy,
          {i_rdy, rnd_req, st_dvld, st_ena, o_vld, o_err, o_g}, {1'b1, 5'd0, 16'd0});
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_i_rdy", i_rdy, 64'(i_rdy), 64'd1);

    h0 = rnd_hs; i0 = issues;
    run_op(8'h0F, 8'h01, 8'hA5, 8'hA5, 1'b0);
    wait_drain("t1_drain");
    check("t1_rnd_handshakes", rnd_hs - h0 == 3, 64'(rnd_hs - h0), 64'd3);
    check("t1_issues", issues - i0 == 3, 64'(issues - i0), 64'd3);

    o_rdy = 1'b0;
    run_op(8'hFF, 8'h01, 8'h3C, 8'hC3, 1'b0);
    n = 0;
    while (!o_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t2_o_vld_seen", o_vld, 64'(o_vld), 64'd1);
    gsnap = o_g;
    repeat (5) begin
      @(negedge clk);
      check("t2_hold", o_vld && o_g == gsnap && !i_rdy, {o_vld, i_rdy, o_g}, {2'b10, gsnap});
    end
    o_rdy = 1'b1;
    @(negedge clk);
    check("t2_rdy_next", !o_vld && i_rdy, {o_vld, i_rdy}, 2'b01);
    wait_drain("t2_drain");

    stall_r1 = 1'b1;
    run_op(8'h0F, 8'h01, 8'($urandom), 8'($urandom), 1'b0);
    wait_drain("t3_drain");
    stall_r1 = 1'b0;

    drop_round = 2;
    run_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    wait_drain("t4_drain");
    drop_round = -1;
    check("t4_idle_cleared", i_rdy && !o_vld && st_p == '0 && st_g == '0 && st_rnd == '0,
          {i_rdy, o_vld, st_p, st_g}, {2'b10, 32'd0});

    run_op(8'h5A, 8'h33, 8'($urandom), 8'($urandom), 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      found = st_ena && !st_dvld && st_round == 2'd1;
      n++;
    end
    check("t5_reach_wait_r1", found, 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("t5_async_clear",
             {rnd_req, st_dvld, st_ena, o_vld, o_err, st_round} == '0 && st_p == '0 &&
             st_g == '0 && st_rnd == '0 && o_g == '0,
             {rnd_req, st_dvld, st_ena, o_vld, o_err, st_p}, {5'd0, 16'd0});
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_i_rdy_after", i_rdy, 64'(i_rdy), 64'd1);
    run_op(8'h03, 8'h01, 8'($urandom), 8'($urandom), 1'b0);
    wait_drain("t5_drain");

    spur_ovld_cnt++;
    repeat (4) @(negedge clk);
    check("t6_idle_ignore", i_rdy && !o_vld && !rnd_req && st_p == '0 && st_g == '0,
          {i_rdy, o_vld, rnd_req, st_p, st_g}, {3'b100, 32'd0});
    spur_rnd_cnt++;
    run_op(8'h0F, 8'h01, 8'($urandom), 8'($urandom), 1'b0);
    wait_drain("t6_drain");

    for (int k = 0; k < 6; k++) begin
      run_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      wait_drain("rand_drain");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
